// File: rtl/mem_pkg.sv
// Shared types and size helpers for the line request sequencer and its watchdog.
package mem_pkg;

  typedef enum logic [1:0] {
    MC_IDLE  = 2'b00,
    MC_READ  = 2'b01,
    MC_WRITE = 2'b11
  } mc_op_e;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WR_ARM,
    ST_WR_STREAM,
    ST_WR_WAIT,
    ST_RD,
    ST_RESP
  } seq_state_e;

  localparam int unsigned DEF_WORD_SIZE      = 32;
  localparam int unsigned DEF_CL_SIZE_WIDTH  = 512;
  localparam int unsigned DEF_ADDR_BITCOUNT  = 64;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;

  function automatic int unsigned fill_count(input int unsigned cl_bits, input int unsigned word_bits);
    return cl_bits / word_bits;
  endfunction

  // A one-word line still needs a 1-bit counter so the vectors stay legal.
  function automatic int unsigned fill_bits(input int unsigned fc);
    return (fc > 1) ? $clog2(fc) : 1;
  endfunction

  function automatic int unsigned line_offset_bits(input int unsigned cl_bits);
    return $clog2(cl_bits / 8);
  endfunction

endpackage

// File: rtl/mem_watchdog.sv
// Saturating cycle counter that flags the cycle in which the timeout limit is reached.
module mem_watchdog #(
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_expired
);

  localparam int unsigned CNT_BITS = $clog2(TIMEOUT + 1);
  localparam logic [CNT_BITS-1:0] LIMIT      = CNT_BITS'(TIMEOUT);
  localparam logic [CNT_BITS-1:0] LIMIT_LAST = CNT_BITS'(TIMEOUT - 1);

  logic [CNT_BITS-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Expiry is flagged one cycle early so the owner can act on the edge the count reaches the limit.
  assign o_expired = i_enable && (r_count >= LIMIT_LAST);

endmodule

// File: rtl/mem_req_seq.sv
// Cache-line request sequencer: streams a line to / collects a line from the memory controller.
module mem_req_seq
  import mem_pkg::*;
#(
  parameter int unsigned WORD_SIZE      = DEF_WORD_SIZE,
  parameter int unsigned CL_SIZE_WIDTH  = DEF_CL_SIZE_WIDTH,
  parameter int unsigned ADDR_BITCOUNT  = DEF_ADDR_BITCOUNT,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [ADDR_BITCOUNT-1:0] req_addr,
  input  logic [CL_SIZE_WIDTH-1:0] req_wline,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic                     resp_write,
  output logic                     resp_err,
  output logic [CL_SIZE_WIDTH-1:0] resp_rline,
  input  logic                     mc_ready,
  output logic [1:0]               mc_op,
  output logic [ADDR_BITCOUNT-1:0] mc_addr,
  output logic [WORD_SIZE-1:0]     mc_wdata,
  input  logic [WORD_SIZE-1:0]     mc_rdata,
  input  logic                     mc_rd_valid,
  input  logic                     mc_tx_done
);

  localparam int unsigned FILL_COUNT  = fill_count(CL_SIZE_WIDTH, WORD_SIZE);
  localparam int unsigned FILL_BITS   = fill_bits(FILL_COUNT);
  localparam int unsigned OFFSET_BITS = line_offset_bits(CL_SIZE_WIDTH);
  localparam logic [FILL_BITS-1:0] LAST_WORD = FILL_BITS'(FILL_COUNT - 1);

  seq_state_e r_state;
  seq_state_e w_next;
  mc_op_e     r_mc_op;

  logic [ADDR_BITCOUNT-1:0]               r_addr;
  logic [FILL_COUNT-1:0][WORD_SIZE-1:0]   r_line;
  logic [FILL_BITS-1:0]                   r_cnt;
  logic                                   r_write;
  logic                                   r_err;
  logic                                   w_accept;
  logic                                   w_wd_en;
  logic                                   w_wd_expired;
  logic                                   w_last_word;
  logic                                   w_unused_addr_bits;

  assign w_accept           = req_valid && req_ready;
  assign w_last_word        = (r_cnt == LAST_WORD);
  assign w_unused_addr_bits = ^req_addr[OFFSET_BITS-1:0];

  mem_watchdog #(
    .TIMEOUT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_enable  (w_wd_en),
    .i_clear   (w_accept),
    .o_expired (w_wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_INIT:      if (mc_ready) w_next = ST_IDLE;
      ST_IDLE:      if (req_valid) w_next = req_write ? ST_WR_ARM : ST_RD;
      ST_WR_ARM:    w_next = ST_WR_STREAM;
      ST_WR_STREAM: if (w_last_word) w_next = ST_WR_WAIT;
      ST_WR_WAIT:   if (mc_tx_done || w_wd_expired) w_next = ST_RESP;
      ST_RD:        if (mc_tx_done || w_wd_expired) w_next = ST_RESP;
      ST_RESP:      if (resp_ready) w_next = ST_IDLE;
      default:      w_next = ST_INIT;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mc_wdata   = '0;
    w_wd_en    = 1'b0;
    case (r_state)
      ST_IDLE:      req_ready = 1'b1;
      ST_WR_STREAM: mc_wdata  = r_line[r_cnt];
      ST_WR_WAIT:   w_wd_en   = 1'b1;
      ST_RD:        w_wd_en   = 1'b1;
      ST_RESP:      resp_valid = 1'b1;
      default:      ;
    endcase
  end

  // A read completes cleanly only if tx_done lands together with the final word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mc_op <= MC_IDLE;
      r_addr  <= '0;
      r_line  <= '0;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_write <= req_write;
            r_line  <= req_wline;
            r_addr  <= {req_addr[ADDR_BITCOUNT-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
            r_cnt   <= '0;
            r_mc_op <= req_write ? MC_WRITE : MC_READ;
          end
        end
        ST_WR_STREAM: r_cnt <= r_cnt + 1'b1;
        ST_WR_WAIT: begin
          if (mc_tx_done) begin
            r_mc_op <= MC_IDLE;
            r_err   <= 1'b0;
          end else if (w_wd_expired) begin
            r_mc_op <= MC_IDLE;
            r_err   <= 1'b1;
          end
        end
        ST_RD: begin
          if (mc_rd_valid) begin
            r_line[r_cnt] <= mc_rdata;
            r_cnt         <= r_cnt + 1'b1;
          end
          if (mc_tx_done) begin
            r_mc_op <= MC_IDLE;
            r_err   <= !(mc_rd_valid && w_last_word);
          end else if (w_wd_expired) begin
            r_mc_op <= MC_IDLE;
            r_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mc_op      = r_mc_op;
  assign mc_addr    = r_addr;
  assign resp_write = r_write;
  assign resp_err   = r_err;
  assign resp_rline = r_line;

endmodule

// File: tb/tb_mem_req_seq.sv
// Self-checking bench for mem_req_seq: directed and randomized line transfers against a line-level model.
module tb_mem_req_seq;

  localparam int WS  = 32;
  localparam int CLW = 512;
  localparam int AW  = 64;
  localparam int TO  = 40;
  localparam int FC  = CLW / WS;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req_valid;
  logic           req_ready;
  logic           req_write;
  logic [AW-1:0]  req_addr;
  logic [CLW-1:0] req_wline;
  logic           resp_valid;
  logic           resp_ready;
  logic           resp_write;
  logic           resp_err;
  logic [CLW-1:0] resp_rline;
  logic           mc_ready;
  logic [1:0]     mc_op;
  logic [AW-1:0]  mc_addr;
  logic [WS-1:0]  mc_wdata;
  logic [WS-1:0]  mc_rdata;
  logic           mc_rd_valid;
  logic           mc_tx_done;

  int total = 0;
  int bad   = 0;

  mem_req_seq #(
    .WORD_SIZE      (WS),
    .CL_SIZE_WIDTH  (CLW),
    .ADDR_BITCOUNT  (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wline   (req_wline),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_write  (resp_write),
    .resp_err    (resp_err),
    .resp_rline  (resp_rline),
    .mc_ready    (mc_ready),
    .mc_op       (mc_op),
    .mc_addr     (mc_addr),
    .mc_wdata    (mc_wdata),
    .mc_rdata    (mc_rdata),
    .mc_rd_valid (mc_rd_valid),
    .mc_tx_done  (mc_tx_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [CLW-1:0] obs, input logic [CLW-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic w, input logic [AW-1:0] a, input logic [CLW-1:0] l);
    req_valid = v;
    req_write = w;
    req_addr  = a;
    req_wline = l;
  endtask

  function automatic logic [CLW-1:0] randLine();
    logic [CLW-1:0] l;
    for (int i = 0; i < FC; i++) l[i*WS +: WS] = $urandom;
    return l;
  endfunction

  function automatic logic [AW-1:0] lineAlign(input logic [AW-1:0] a);
    return a & ~(AW'(CLW / 8) - 1);
  endfunction

  task automatic checkReset(input string tag);
    checkOutput({tag, "_req_ready"}, req_ready, 0);
    checkOutput({tag, "_resp_valid"}, resp_valid, 0);
    checkOutput({tag, "_resp_err"}, resp_err, 0);
    checkOutput({tag, "_resp_write"}, resp_write, 0);
    checkOutput({tag, "_resp_rline"}, resp_rline, 0);
    checkOutput({tag, "_mc_op"}, mc_op, 0);
    checkOutput({tag, "_mc_addr"}, mc_addr, 0);
    checkOutput({tag, "_mc_wdata"}, mc_wdata, 0);
  endtask

  // Response must stay put while the core stalls, then drop after acceptance.
  task automatic respCheck(input logic expWrite, input logic expErr, input logic [CLW-1:0] expLine,
                           input bit chkLine, input int hold);
    checkOutput("resp_valid", resp_valid, 1);
    checkOutput("resp_op_idle", mc_op, 0);
    checkOutput("resp_write", resp_write, expWrite);
    checkOutput("resp_err", resp_err, expErr);
    if (chkLine) checkOutput("resp_rline", resp_rline, expLine);
    checkOutput("resp_no_accept", req_ready, 0);
    for (int h = 0; h < hold; h++) begin
      resp_ready = 1'b0;
      tick();
      checkOutput("hold_valid", resp_valid, 1);
      checkOutput("hold_err", resp_err, expErr);
      checkOutput("hold_write", resp_write, expWrite);
      if (chkLine) checkOutput("hold_rline", resp_rline, expLine);
      checkOutput("hold_no_accept", req_ready, 0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    checkOutput("resp_dropped", resp_valid, 0);
    checkOutput("back_to_idle", req_ready, 1);
  endtask

  // delay < 0 means the controller never signals completion.
  task automatic runWrite(input logic [AW-1:0] addr, input logic [CLW-1:0] line, input int delay, input int hold);
    int edges;
    checkOutput("wr_start_ready", req_ready, 1);
    applyStimulus(1'b1, 1'b1, addr, line);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("wr_op", mc_op, 2'b11);
    checkOutput("wr_addr", mc_addr, lineAlign(addr));
    checkOutput("wr_busy", req_ready, 0);
    for (int i = 0; i < FC; i++) begin
      tick();
      checkOutput($sformatf("wr_word%0d", i), mc_wdata, line[i*WS +: WS]);
    end
    checkOutput("wr_stream_op", mc_op, 2'b11);
    tick();
    edges = 0;
    if (delay >= 0) begin
      for (int j = 0; j < delay; j++) begin
        checkOutput("wr_wait_op", mc_op, 2'b11);
        checkOutput("wr_wait_novalid", resp_valid, 0);
        tick();
      end
      mc_tx_done = 1'b1;
      tick();
      mc_tx_done = 1'b0;
      respCheck(1'b1, 1'b0, '0, 1'b0, hold);
    end else begin
      while (!resp_valid && edges < TO + 10) begin
        tick();
        edges++;
      end
      checkOutput("wr_timeout_cycles", edges, TO);
      respCheck(1'b1, 1'b1, '0, 1'b0, hold);
    end
  endtask

  // doneWord < 0 means the controller stalls after nWords and the watchdog must fire.
  task automatic runRead(input logic [AW-1:0] addr, input int nWords, input int doneWord,
                         input bit gaps, input bit seqData, input int hold);
    logic [CLW-1:0] expLine;
    int edges;
    bit doneSeen;
    expLine = '0;
    checkOutput("rd_start_ready", req_ready, 1);
    applyStimulus(1'b1, 1'b0, addr, '0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0);
    checkOutput("rd_op", mc_op, 2'b01);
    checkOutput("rd_addr", mc_addr, lineAlign(addr));
    checkOutput("rd_busy", req_ready, 0);
    edges    = 0;
    doneSeen = 0;
    for (int k = 0; k < nWords && !doneSeen; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        tick();
        edges++;
        checkOutput("rd_gap_novalid", resp_valid, 0);
      end
      mc_rd_valid = 1'b1;
      mc_rdata    = seqData ? WS'(32'hB0 + k) : WS'($urandom);
      expLine[k*WS +: WS] = mc_rdata;
      if (k == doneWord) begin
        mc_tx_done = 1'b1;
        doneSeen   = 1;
      end
      tick();
      edges++;
      mc_rd_valid = 1'b0;
      mc_tx_done  = 1'b0;
      if (!doneSeen) checkOutput("rd_novalid", resp_valid, 0);
    end
    if (doneSeen) begin
      respCheck(1'b0, (doneWord != FC - 1), expLine, 1'b1, hold);
    end else begin
      while (!resp_valid && edges < TO + 10) begin
        tick();
        edges++;
      end
      checkOutput("rd_timeout_cycles", edges, TO);
      respCheck(1'b0, 1'b1, expLine, 1'b1, hold);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: observed=stuck expected=finish");
    $fatal(1, "[TB] simulation did not terminate");
  end

  initial begin
    logic [CLW-1:0] line;
    logic [AW-1:0]  addr;
    rst_n       = 1'b0;
    mc_ready    = 1'b0;
    resp_ready  = 1'b0;
    mc_rdata    = '0;
    mc_rd_valid = 1'b0;
    mc_tx_done  = 1'b0;
    applyStimulus(1'b0, 1'b0, '0, '0);

    tick();
    checkReset("rst");
    rst_n = 1'b1;
    tick();
    checkOutput("init_cycle1_ready", req_ready, 0);
    tick();
    checkOutput("init_cycle2_ready", req_ready, 0);
    mc_ready = 1'b1;
    checkOutput("init_cycle3_ready", req_ready, 0);
    tick();
    checkOutput("init_ready_rise", req_ready, 1);

    mc_tx_done  = 1'b1;
    mc_rd_valid = 1'b1;
    tick();
    mc_tx_done  = 1'b0;
    mc_rd_valid = 1'b0;
    checkOutput("idle_ignore_valid", resp_valid, 0);
    checkOutput("idle_ignore_ready", req_ready, 1);
    checkOutput("idle_ignore_op", mc_op, 0);

    for (int i = 0; i < FC; i++) line[i*WS +: WS] = 32'hA000_0000 + i;
    runWrite(64'h1047, line, 4, 0);
    runRead(64'h2000, FC, FC - 1, 1'b0, 1'b1, 0);
    runRead(64'h3010, FC, 9, 1'b0, 1'b0, 1);
    runWrite(64'h4abc, randLine(), -1, 0);
    runRead(64'h5000, 5, -1, 1'b0, 1'b0, 0);
    runRead(64'h6000, FC, FC - 1, 1'b0, 1'b0, 20);

    for (int n = 0; n < 8; n++) begin
      addr = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) begin
        runWrite(addr, randLine(), $urandom_range(0, 6), $urandom_range(0, 3));
      end else begin
        runRead(addr, FC, ($urandom_range(0, 3) == 0) ? $urandom_range(0, FC - 2) : FC - 1,
                1'b1, 1'b0, $urandom_range(0, 3));
      end
    end

    applyStimulus(1'b1, 1'b0, 64'h7777, '0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 5; k++) begin
      mc_rd_valid = 1'b1;
      mc_rdata    = $urandom;
      tick();
    end
    mc_rd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkReset("midrd");
    tick();
    checkReset("midrd_held");
    rst_n = 1'b1;
    tick();
    checkOutput("midrd_recover_ready", req_ready, 1);
    checkOutput("midrd_no_resp", resp_valid, 0);
    runWrite(64'h8040, randLine(), 2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_req_seq.md
# mem_req_seq

Line-granular request sequencer that sits directly upstream of the memory controller. It accepts full cache-line read and write requests from the core over a valid/ready handshake. It drives the controller's op/address lines and streams the line one word per cycle into the controller, or collects the words the controller streams back. It then returns a response over a second valid/ready handshake, with a watchdog that turns a stalled transfer into an error response.

## Interface
- WORD_SIZE, 32, controller word width
- CL_SIZE_WIDTH, 512, line width; FILL_COUNT = CL_SIZE_WIDTH/WORD_SIZE words per line
- ADDR_BITCOUNT, 64, address width
- TIMEOUT_CYCLES, 4096, max cycles waiting on the controller per transfer
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  core request valid
- req_ready  out  1  sequencer can accept a request
- req_write  in  1  1 = write line, 0 = read line
- req_addr  in  ADDR_BITCOUNT  byte address; low $clog2(CL_SIZE_WIDTH/8) bits ignored
- req_wline  in  CL_SIZE_WIDTH  write data; word i = bits [(i+1)*WORD_SIZE-1 : i*WORD_SIZE]
- resp_valid  out  1  response valid
- resp_ready  in  1  core accepts response
- resp_write  out  1  echo of req_write
- resp_err  out  1  transfer ended by timeout or protocol error
- resp_rline  out  CL_SIZE_WIDTH  read line, same word ordering
- mc_ready  in  1  controller initialised
- mc_op  out  2  00 idle, 01 read, 11 write (registered)
- mc_addr  out  ADDR_BITCOUNT  line-aligned address (registered)
- mc_wdata  out  WORD_SIZE  write word to controller
- mc_rdata  in  WORD_SIZE  read word from controller
- mc_rd_valid  in  1  mc_rdata carries one read word
- mc_tx_done  in  1  last word of a read / write committed

## Operation
- States: INIT, IDLE, WR_ARM, WR_STREAM, WR_WAIT, RD, RESP.
- INIT: req_ready=0. Go to IDLE on the first cycle mc_ready=1.
- IDLE: req_ready=1. On req_valid&&req_ready, latch write flag, line and aligned address (low bits zeroed). Set mc_addr, clear word counter and watchdog.
  - Write: mc_op<=11, go to WR_ARM.
  - Read: mc_op<=01, go to RD.
- WR_ARM: one cycle. The controller takes its op this cycle and consumes no data. Go to WR_STREAM.
- WR_STREAM: mc_wdata = latched word[cnt]; cnt increments each cycle. After word FILL_COUNT-1, go to WR_WAIT.
- WR_WAIT: hold mc_op=11 until mc_tx_done. Then mc_op<=00 and go to RESP with err=0.
- RD: hold mc_op=01. Each mc_rd_valid stores mc_rdata into word[cnt] and increments cnt.
  - mc_tx_done must coincide with the rd_valid for cnt=FILL_COUNT-1. If it does, err=0.
  - If tx_done arrives at any other cnt, err=1.
  - On either outcome, mc_op<=00 and go to RESP.
- Watchdog: counts every cycle in WR_WAIT and RD. On reaching TIMEOUT_CYCLES, mc_op<=00, err=1, go to RESP. The partial line is returned as-is.
- RESP: resp_valid=1, fields stable. On resp_ready, go to IDLE.
- mc_tx_done or mc_rd_valid arriving in IDLE/INIT/RESP is ignored.
- cnt width is $clog2(FILL_COUNT). The watchdog width is $clog2(TIMEOUT_CYCLES+1) and it saturates.

## Timing
- Reset: state INIT, req_ready=0, resp_valid=0, resp_err=0, resp_write=0, resp_rline=0, mc_op=00, mc_addr=0, mc_wdata=0, counters 0.
- Accept at edge E; mc_op/mc_addr valid from E+1.
- Write: mc_op=11 from cycle A. Word i is presented in cycle A+1+i, so words 0..FILL_COUNT-1 occupy A+1..A+FILL_COUNT.
- mc_op falls to 00 on the edge that samples mc_tx_done, so the controller never sees a repeated op.
- resp_valid is asserted the cycle after tx_done or the timeout; minimum latency is one cycle.
- req_ready is combinational from state (IDLE only). There is no back-to-back acceptance while a response is pending.
- rst_n asserted mid-transfer: immediate return to reset values. The transfer is abandoned and no response is issued.

## Structure
- Shared package mem_pkg: mc opcode enum (IDLE/READ/WRITE, 2-bit), FILL_COUNT/FILL_BITS derivation, line-offset-bits constant.
- No sub-modules required. The watchdog may be split out as mem_watchdog (enable, clear, saturate, expired).

## Test plan
- Reset then mc_ready=1 at cycle 3: req_ready rises at cycle 4; all outputs 0 before.
- Write addr 0x1047, line word i = 0xA000_0000+i, tx_done 5 cycles after stream:
  - mc_addr=0x1040.
  - mc_wdata sequence 0xA0000000..0xA000000F on consecutive cycles after WR_ARM.
  - mc_op 00 the cycle after tx_done; resp err=0, write=1.
- Read addr 0x2000, 16 rd_valid words 0xB0+i with tx_done on the 16th: resp_rline word i = 0xB0+i, err=0.
- Read with tx_done on the 10th rd_valid: resp_err=1, mc_op=00 next cycle.
- TIMEOUT_CYCLES=8, write with no tx_done: resp_valid 8 cycles into WR_WAIT, err=1.
- Hold resp_ready=0 for 20 cycles: resp fields stable, req_ready=0. Assert rst_n=0 mid-read: all outputs return to reset values immediately.
